// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format enum, field positions and decode function
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_src_e;

  // Widest supported immediate; narrower builds keep the low bits.
  localparam int MAX_XLEN = 64;

  // Instruction field positions used by the base-ISA immediate formats.
  localparam int SIGN_BIT   = 31;
  localparam int I_LO       = 20;
  localparam int S_HI_LO    = 25;
  localparam int S_LO_HI    = 11;
  localparam int S_LO_LO    = 7;
  localparam int U_LO       = 12;
  localparam int SHAMT_LO   = 20;
  localparam int SHAMT32_HI = 24;
  localparam int SHAMT64_HI = 25;
  localparam int ZIMM_HI    = 19;
  localparam int ZIMM_LO    = 15;

  typedef struct packed {
    logic                ill;
    logic [MAX_XLEN-1:0] imm;
  } imm_dec_t;

  // Decode to the widest format; callers keep the low xlen bits, which
  // is exactly the sign/zero-extended result for a 32-bit build too.
  function automatic imm_dec_t imm_decode(input logic [31:0] instr,
                                          input imm_src_e    src,
                                          input int          xlen);
    imm_dec_t r;
    r.ill = 1'b0;
    r.imm = '0;
    case (src)
      IMM_I: r.imm = {{52{instr[SIGN_BIT]}}, instr[SIGN_BIT:I_LO]};
      IMM_S: r.imm = {{52{instr[SIGN_BIT]}}, instr[SIGN_BIT:S_HI_LO],
                      instr[S_LO_HI:S_LO_LO]};
      IMM_B: r.imm = {{51{instr[SIGN_BIT]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_U: r.imm = {{32{instr[SIGN_BIT]}}, instr[SIGN_BIT:U_LO], 12'b0};
      IMM_J: r.imm = {{43{instr[SIGN_BIT]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: begin
        if (xlen == 64) r.imm = {58'b0, instr[SHAMT64_HI:SHAMT_LO]};
        else            r.imm = {59'b0, instr[SHAMT32_HI:SHAMT_LO]};
      end
      IMM_ZIMM: r.imm = {59'b0, instr[ZIMM_HI:ZIMM_LO]};
      default: begin
        r.imm = '0;
        r.ill = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_pipe_slice.sv
// rtl/imm_pipe_slice.sv - one valid/ready register slice
module imm_pipe_slice #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // A full slice may reload in the same cycle its entry is taken.
  assign up_ready = !valid_q || dn_ready;
  assign dn_valid = valid_q;
  assign dn_data  = data_q;

  // Load on upstream transfer, empty when taken with nothing arriving.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (up_valid && up_ready) begin
      valid_q <= 1'b1;
      data_q  <= up_data;
    end else if (dn_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32I immediate generator with handshakes
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  imm_src_e        in_imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  imm_dec_t        dec;
  logic [STAGES:0] vld;
  logic [STAGES:0] rdy;
  logic [XLEN:0]   dat [STAGES+1];
  logic            unused_dec;

  assign dec = imm_decode(in_instr, in_imm_src, XLEN);

  // Upper decode bits are only meaningful for a 64-bit build.
  assign unused_dec = ^dec.imm;

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign dat[0]      = {dec.ill, dec.imm[XLEN-1:0]};
  assign rdy[STAGES] = out_ready;
  assign out_valid   = vld[STAGES];
  assign out_illegal = dat[STAGES][XLEN];
  assign out_imm     = dat[STAGES][XLEN-1:0];

  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    imm_pipe_slice #(.W(XLEN + 1)) u_slice (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (vld[g]),
      .up_ready (rdy[g]),
      .up_data  (dat[g]),
      .dn_valid (vld[g+1]),
      .dn_ready (rdy[g+1]),
      .dn_data  (dat[g+1])
    );
  end

  // Legal build configurations.
  a_xlen: assert property (@(posedge clk) (XLEN == 32 || XLEN == 64));
  a_stages: assert property (@(posedge clk) (STAGES >= 1 && STAGES <= 3));

  // A held output must not change until the consumer takes it.
  a_hold: assert property (@(posedge clk)
    $past(out_valid && !out_ready && !flush && !reset) |->
      (out_valid && out_imm == $past(out_imm) && out_illegal == $past(out_illegal)));

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    logic [63:0] imm;
    logic        ill;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        fl  [3];
  logic        iv  [3];
  logic        ir  [3];
  logic        orr [3];
  logic        ov  [3];
  logic        oill[3];
  logic [31:0] ii  [3];
  imm_src_e    src [3];
  logic [31:0] oi0;
  logic [63:0] oi1;
  logic [31:0] oi2;
  logic [63:0] oi  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   pops1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign oi[0] = {32'h0, oi0};
  assign oi[1] = oi1;
  assign oi[2] = {32'h0, oi2};

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .reset(rst[0]), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_instr(ii[0]), .in_imm_src(src[0]), .out_valid(ov[0]), .out_ready(orr[0]),
    .out_imm(oi0), .out_illegal(oill[0]));

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_b (
    .clk(clk), .reset(rst[1]), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_instr(ii[1]), .in_imm_src(src[1]), .out_valid(ov[1]), .out_ready(orr[1]),
    .out_imm(oi1), .out_illegal(oill[1]));

  imm_gen_pipe #(.XLEN(32), .STAGES(3)) u_c (
    .clk(clk), .reset(rst[2]), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_instr(ii[2]), .in_imm_src(src[2]), .out_valid(ov[2]), .out_ready(orr[2]),
    .out_imm(oi2), .out_illegal(oill[2]));

  function automatic int stg(input int k);
    return k + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every transfer on an output port must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && orr[k]) begin : mon
        exp_t e;
        int   n;
        n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (n == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out inst %0d: got imm %h with empty scoreboard, required no output", k, oi[k]);
        end else begin
          case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("imm_inst%0d", k), oi[k], e.imm);
          chk($sformatf("ill_inst%0d", k), {63'b0, oill[k]}, {63'b0, e.ill});
          if (e.cyc >= 0) chk($sformatf("latency_inst%0d", k), 64'(cyc), 64'(e.cyc));
          if (k == 1) pops1.push_back(cyc);
        end
      end
    end
  end

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Present one entry and hold it until accepted; called at posedge+1.
  task automatic send(input int k, input logic [31:0] ins, input imm_src_e s,
                      input logic [63:0] ei, input logic eil, input bit keep, input bit lat);
    exp_t e;
    bit   done;
    done = 1'b0;
    iv[k] = 1'b1;
    ii[k] = ins;
    src[k] = s;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (ir[k]) begin
        done = 1'b1;
        e.imm = ei;
        e.ill = eil;
        e.cyc = lat ? cyc + stg(k) : -1;
        @(posedge clk);
        if (keep) push(k, e);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst %0d: in_ready stayed 0, required 1", k);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; fl[k] = 1'b0; iv[k] = 1'b0; orr[k] = 1'b1;
      ii[k] = '0; src[k] = IMM_I;
    end
    cycles(2);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid%0d", k), {63'b0, ov[k]}, 64'd0);
      chk($sformatf("rst_out_imm%0d", k), oi[k], 64'd0);
      chk($sformatf("rst_out_ill%0d", k), {63'b0, oill[k]}, 64'd0);
      chk($sformatf("rst_in_ready%0d", k), {63'b0, ir[k]}, 64'd1);
    end
    @(posedge clk); #1;

    // XLEN=32, one slice: back-to-back formats, reserved code, recovery.
    send(0, 32'hFFF00093, IMM_I,     64'h00000000FFFFFFFF, 1'b0, 1, 1);
    send(0, 32'hFE512E23, IMM_S,     64'h00000000FFFFFFFC, 1'b0, 1, 1);
    send(0, 32'hFE000CE3, IMM_B,     64'h00000000FFFFFFF8, 1'b0, 1, 1);
    send(0, 32'h123450B7, IMM_U,     64'h0000000012345000, 1'b0, 1, 1);
    send(0, 32'h0010006F, IMM_J,     64'h0000000000000800, 1'b0, 1, 1);
    send(0, 32'h03F01013, IMM_SHAMT, 64'h000000000000001F, 1'b0, 1, 1);
    send(0, 32'hFFFFFFFF, IMM_RSVD,  64'h0000000000000000, 1'b1, 1, 1);
    send(0, 32'h00100093, IMM_I,     64'h0000000000000001, 1'b0, 1, 1);
    iv[0] = 1'b0;
    cycles(4);

    // XLEN=64, two slices, free-flowing.
    send(1, 32'h80000037, IMM_U,     64'hFFFFFFFF80000000, 1'b0, 1, 1);
    send(1, 32'h03F01013, IMM_SHAMT, 64'h000000000000003F, 1'b0, 1, 1);
    send(1, 32'h0007D073, IMM_ZIMM,  64'h000000000000000F, 1'b0, 1, 1);
    iv[1] = 1'b0;
    cycles(5);

    // Backpressure: two slices fill, third entry waits, then drain in order.
    orr[1] = 1'b0;
    send(1, 32'hFFF00093, IMM_I, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1, 0);
    send(1, 32'hFE512E23, IMM_S, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1, 0);
    iv[1] = 1'b1; ii[1] = 32'h0010006F; src[1] = IMM_J;
    @(negedge clk);
    chk("bp_in_ready_low", {63'b0, ir[1]}, 64'd0);
    chk("bp_out_valid", {63'b0, ov[1]}, 64'd1);
    chk("bp_held_imm", oi[1], 64'hFFFFFFFFFFFFFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_still_low", {63'b0, ir[1]}, 64'd0);
    chk("bp_held_imm_stable", oi[1], 64'hFFFFFFFFFFFFFFFF);
    @(posedge clk); #1;
    pops1.delete();
    orr[1] = 1'b1;
    send(1, 32'h0010006F, IMM_J, 64'h0000000000000800, 1'b0, 1, 0);
    iv[1] = 1'b0;
    cycles(5);
    chk("bp_drain_count", 64'(pops1.size()), 64'd3);
    if (pops1.size() == 3) begin
      chk("bp_drain_gap1", 64'(pops1[1] - pops1[0]), 64'd1);
      chk("bp_drain_gap2", 64'(pops1[2] - pops1[1]), 64'd1);
    end

    // Three slices full under backpressure, then flush.
    orr[2] = 1'b0;
    send(2, 32'hFFF00093, IMM_I, 64'h0, 1'b0, 0, 0);
    send(2, 32'h123450B7, IMM_U, 64'h0, 1'b0, 0, 0);
    send(2, 32'h0010006F, IMM_J, 64'h0, 1'b0, 0, 0);
    iv[2] = 1'b0;
    @(negedge clk);
    chk("fl_full_valid", {63'b0, ov[2]}, 64'd1);
    chk("fl_full_ready", {63'b0, ir[2]}, 64'd0);
    @(posedge clk); #1;
    fl[2] = 1'b1;
    cycles(1);
    fl[2] = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", {63'b0, ov[2]}, 64'd0);
    chk("fl_in_ready", {63'b0, ir[2]}, 64'd1);
    @(posedge clk); #1;
    orr[2] = 1'b1;
    cycles(6);

    // Reset with full pipeline and flush together, then a fresh entry.
    orr[2] = 1'b0;
    send(2, 32'hFE000CE3, IMM_B, 64'h0, 1'b0, 0, 0);
    send(2, 32'hFE512E23, IMM_S, 64'h0, 1'b0, 0, 0);
    send(2, 32'h0007D073, IMM_ZIMM, 64'h0, 1'b0, 0, 0);
    iv[2] = 1'b0;
    rst[2] = 1'b1;
    fl[2] = 1'b1;
    cycles(1);
    rst[2] = 1'b0;
    fl[2] = 1'b0;
    @(negedge clk);
    chk("rs_out_valid", {63'b0, ov[2]}, 64'd0);
    chk("rs_out_imm", oi[2], 64'd0);
    chk("rs_out_ill", {63'b0, oill[2]}, 64'd0);
    chk("rs_in_ready", {63'b0, ir[2]}, 64'd1);
    @(posedge clk); #1;
    orr[2] = 1'b1;
    send(2, 32'hFFF00093, IMM_I, 64'h00000000FFFFFFFF, 1'b0, 1, 1);
    iv[2] = 1'b0;
    cycles(6);

    chk("sb_empty0", 64'(q0.size()), 64'd0);
    chk("sb_empty1", 64'(q1.size()), 64'd0);
    chk("sb_empty2", 64'(q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
